// File: rtl/pipelined_adder.sv
// Pipelined add/subtract: the carry chain is cut into STAGES equal slices, one slice per register stage.
// Optional feature macro PIPELINED_ADDER_SAT_EN: saturate the signed result on overflow instead of wrapping.
module pipelined_adder #(
    parameter int WIDTH  = 8,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             cout,
    output logic             ovf
);
    localparam int SW = WIDTH / STAGES;

    generate
        if (WIDTH < 2 || STAGES < 1 || STAGES > WIDTH || (WIDTH % STAGES) != 0) begin : g_bad_cfg
            $error("pipelined_adder: WIDTH must be >= 2 and divisible by STAGES, 1 <= STAGES <= WIDTH");
        end
    endgenerate

    // Ripple one slice; returns {carry out, carry into slice MSB, slice sum}.
    function automatic logic [SW+1:0] add_slice(input logic [SW-1:0] x,
                                                input logic [SW-1:0] y,
                                                input logic          ci);
        logic [SW-1:0] sm;
        logic          c;
        logic          cm;
        sm = '0;
        c  = ci;
        cm = ci;
        for (int i = 0; i < SW; i++) begin
            cm    = c;
            sm[i] = x[i] ^ y[i] ^ c;
            c     = (x[i] & y[i]) | (x[i] & c) | (y[i] & c);
        end
        return {c, cm, sm};
    endfunction

    logic [WIDTH-1:0] a_q   [STAGES];
    logic [WIDTH-1:0] b_q   [STAGES];
    logic [WIDTH-1:0] sum_q [STAGES];
    logic             c_q   [STAGES];
    logic             cm_q  [STAGES];
    logic             vld_q [STAGES];

    logic [WIDTH-1:0] a_d   [STAGES];
    logic [WIDTH-1:0] b_d   [STAGES];
    logic [WIDTH-1:0] sum_d [STAGES];
    logic             c_d   [STAGES];
    logic             cm_d  [STAGES];
    logic             vld_d [STAGES];

    logic [WIDTH-1:0] b_eff;
    logic [SW+1:0]    slice_r;
    logic             advance;
    logic             ovf_raw;
    logic [WIDTH-1:0] res;

    // Subtraction is folded into stage 0 as a + ~b + 1, so later stages only ever add.
    always_comb begin
        b_eff   = sub ? ~b : b;
        slice_r = add_slice(a[SW-1:0], b_eff[SW-1:0], sub | cin);

        a_d[0]            = a;
        b_d[0]            = b_eff;
        sum_d[0]          = '0;
        sum_d[0][SW-1:0]  = slice_r[SW-1:0];
        c_d[0]            = slice_r[SW+1];
        cm_d[0]           = slice_r[SW];
        vld_d[0]          = in_valid;

        for (int k = 1; k < STAGES; k++) begin
            slice_r = add_slice(a_q[k-1][k*SW +: SW], b_q[k-1][k*SW +: SW], c_q[k-1]);
            a_d[k]                 = a_q[k-1];
            b_d[k]                 = b_q[k-1];
            sum_d[k]               = sum_q[k-1];
            sum_d[k][k*SW +: SW]   = slice_r[SW-1:0];
            c_d[k]                 = slice_r[SW+1];
            cm_d[k]                = slice_r[SW];
            vld_d[k]               = vld_q[k-1];
        end
    end

    assign out_valid = vld_q[STAGES-1];
    assign advance   = out_ready | ~out_valid;
    assign in_ready  = advance;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < STAGES; k++) vld_q[k] <= 1'b0;
        end else if (advance) begin
            for (int k = 0; k < STAGES; k++) vld_q[k] <= vld_d[k];
        end
    end

    // Datapath registers carry no reset; outputs are masked by out_valid instead.
    always_ff @(posedge clk) begin
        if (advance) begin
            for (int k = 0; k < STAGES; k++) begin
                a_q[k]   <= a_d[k];
                b_q[k]   <= b_d[k];
                sum_q[k] <= sum_d[k];
                c_q[k]   <= c_d[k];
                cm_q[k]  <= cm_d[k];
            end
        end
    end

    assign ovf_raw = cm_q[STAGES-1] ^ c_q[STAGES-1];

`ifdef PIPELINED_ADDER_SAT_EN
    assign res = !ovf_raw ? sum_q[STAGES-1] :
                 a_q[STAGES-1][WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
`else
    assign res = sum_q[STAGES-1];
`endif

    assign s    = out_valid ? res : '0;
    assign cout = out_valid & c_q[STAGES-1];
    assign ovf  = out_valid & ovf_raw;

endmodule

// File: tb/tb_pipelined_adder.sv
// Directed bench for pipelined_adder (WIDTH=8, STAGES=2) with hand-computed expected results.
module tb_pipelined_adder;
    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] a = '0;
    logic [7:0] b = '0;
    logic       cin = 1'b0;
    logic       sub = 1'b0;
    logic       out_valid;
    logic       out_ready = 1'b1;
    logic [7:0] s;
    logic       cout;
    logic       ovf;

    int total = 0;
    int bad   = 0;

`ifdef PIPELINED_ADDER_SAT_EN
    localparam logic [7:0] S_7F_P_01 = 8'h7F;
    localparam logic [7:0] S_80_M_01 = 8'h80;
    localparam logic [7:0] S_80_P_80 = 8'h80;
`else
    localparam logic [7:0] S_7F_P_01 = 8'h80;
    localparam logic [7:0] S_80_M_01 = 8'h7F;
    localparam logic [7:0] S_80_P_80 = 8'h00;
`endif

    pipelined_adder #(.WIDTH(8), .STAGES(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .s         (s),
        .cout      (cout),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [7:0] av, input logic [7:0] bv, input logic ci, input logic sb);
        in_valid = 1'b1;
        a = av;
        b = bv;
        cin = ci;
        sub = sb;
    endtask

    // One isolated operation: accept, check latency, check result, let it drain.
    task automatic op1(input string tag, input logic [7:0] av, input logic [7:0] bv,
                       input logic ci, input logic sb,
                       input logic [7:0] es, input logic ec, input logic eo);
        drive(av, bv, ci, sb);
        #1;
        chk({tag, ".in_ready"}, in_ready, 1'b1);
        step();
        in_valid = 1'b0;
        chk({tag, ".lat1_vld"}, out_valid, 1'b0);
        step();
        chk({tag, ".vld"}, out_valid, 1'b1);
        chk({tag, ".s"}, s, es);
        chk({tag, ".cout"}, cout, ec);
        chk({tag, ".ovf"}, ovf, eo);
        step();
    endtask

    initial begin
        #3 rst = 1'b1;
        #1;
        chk("rst.vld", out_valid, 1'b0);
        chk("rst.rdy", in_ready, 1'b1);
        chk("rst.s", s, 8'h00);
        chk("rst.cout", cout, 1'b0);
        chk("rst.ovf", ovf, 1'b0);
        step();
        step();
        rst = 1'b0;

        op1("ff_p_01", 8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        op1("7f_p_01", 8'h7F, 8'h01, 1'b0, 1'b0, S_7F_P_01, 1'b0, 1'b1);
        op1("05_m_07", 8'h05, 8'h07, 1'b0, 1'b1, 8'hFE, 1'b0, 1'b0);
        op1("05_m_07c", 8'h05, 8'h07, 1'b1, 1'b1, 8'hFE, 1'b0, 1'b0);
        op1("80_m_01", 8'h80, 8'h01, 1'b0, 1'b1, S_80_M_01, 1'b1, 1'b1);
        op1("10_p_20c", 8'h10, 8'h20, 1'b1, 1'b0, 8'h31, 1'b0, 1'b0);
        op1("0f_p_01", 8'h0F, 8'h01, 1'b0, 1'b0, 8'h10, 1'b0, 1'b0);
        op1("80_p_80", 8'h80, 8'h80, 1'b0, 1'b0, S_80_P_80, 1'b1, 1'b1);
        op1("09_m_09", 8'h09, 8'h09, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0);

        // Back-to-back inputs with a consumer stall
        drive(8'h01, 8'h01, 1'b0, 1'b0);
        step();
        drive(8'h02, 8'h02, 1'b0, 1'b0);
        step();
        out_ready = 1'b0;
        drive(8'h03, 8'h03, 1'b0, 1'b0);
        #1;
        chk("stall.vld0", out_valid, 1'b1);
        chk("stall.s0", s, 8'h02);
        chk("stall.rdy0", in_ready, 1'b0);
        for (int i = 0; i < 2; i++) begin
            step();
            chk("stall.vld_hold", out_valid, 1'b1);
            chk("stall.s_hold", s, 8'h02);
            chk("stall.rdy_hold", in_ready, 1'b0);
        end
        out_ready = 1'b1;
        #1;
        chk("stall.rdy_rel", in_ready, 1'b1);
        step();
        chk("drain.s1", s, 8'h04);
        chk("drain.v1", out_valid, 1'b1);
        drive(8'h04, 8'h04, 1'b0, 1'b0);
        step();
        in_valid = 1'b0;
        chk("drain.s2", s, 8'h06);
        chk("drain.v2", out_valid, 1'b1);
        step();
        chk("drain.s3", s, 8'h08);
        chk("drain.v3", out_valid, 1'b1);
        step();
        chk("drain.empty", out_valid, 1'b0);

        // Reset with operations in flight
        drive(8'h11, 8'h11, 1'b0, 1'b0);
        step();
        drive(8'h22, 8'h22, 1'b0, 1'b0);
        step();
        in_valid = 1'b0;
        rst = 1'b1;
        #1;
        chk("midrst.vld", out_valid, 1'b0);
        chk("midrst.s", s, 8'h00);
        chk("midrst.rdy", in_ready, 1'b1);
        step();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("midrst.no_result", out_valid, 1'b0);
        end

        // Bubble in the middle of a stream
        drive(8'h10, 8'h20, 1'b0, 1'b0);
        step();
        in_valid = 1'b0;
        step();
        chk("bub.v0", out_valid, 1'b1);
        chk("bub.s0", s, 8'h30);
        drive(8'h01, 8'h01, 1'b0, 1'b0);
        step();
        in_valid = 1'b0;
        chk("bub.v1", out_valid, 1'b0);
        step();
        chk("bub.v2", out_valid, 1'b1);
        chk("bub.s2", s, 8'h02);
        step();
        chk("bub.end", out_valid, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/pipelined_adder.md
PIPELINED_ADDER -- requirements
Module: pipelined_adder

Interface
REQ-001 SHALL have parameter WIDTH, default 8: operand and result width in bits, minimum 2.
REQ-002 SHALL have parameter STAGES, default 2: number of pipeline register stages; WIDTH SHALL be divisible by STAGES, and STAGES SHALL be between 1 and WIDTH.
REQ-003 SHALL have port clk, input, 1 bit: single clock, rising-edge active.
REQ-004 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port in_valid, input, 1 bit: the operand set is valid.
REQ-006 SHALL have port in_ready, output, 1 bit: the block accepts an operand set this cycle.
REQ-007 SHALL have port a, input, WIDTH bits: operand A.
REQ-008 SHALL have port b, input, WIDTH bits: operand B.
REQ-009 SHALL have port cin, input, 1 bit: carry-in, used in add mode only.
REQ-010 SHALL have port sub, input, 1 bit: 0 selects add, 1 selects subtract.
REQ-011 SHALL have port out_valid, output, 1 bit: the result is valid.
REQ-012 SHALL have port out_ready, input, 1 bit: the consumer accepts the result.
REQ-013 SHALL have port s, output, WIDTH bits: sum or difference.
REQ-014 SHALL have port cout, output, 1 bit: carry out of the MSB.
REQ-015 SHALL have port ovf, output, 1 bit: two's-complement signed overflow.

Function
REQ-016 SHALL compute a + b + cin when sub=0, and a + ~b + 1 when sub=1 (cin ignored).
REQ-017 SHALL split the carry chain into STAGES slices of WIDTH/STAGES bits each; slice k is resolved in pipeline stage k.
REQ-018 SHALL carry the unprocessed operand bits, the partial sum and the inter-slice carry forward in each stage's registers.
REQ-019 SHALL have a fixed latency of STAGES cycles from an accepted input (in_valid and in_ready on the same edge) to out_valid, absent stalls.
REQ-020 SHALL define advance = out_ready OR NOT out_valid; in_ready SHALL equal advance, combinationally.
REQ-021 SHALL shift all stage registers and valid bits one stage when advance=1, and hold every register when advance=0.
REQ-022 SHALL propagate an empty slot (bubble) as valid=0 when in_valid=0 and advance=1; bubbles are not compacted.
REQ-023 SHALL sustain a throughput of one result per cycle while out_ready=1.
REQ-024 SHALL set cout to the final carry; in subtract mode cout=1 means no borrow.
REQ-025 SHALL set ovf = carry into MSB XOR carry out of MSB.
REQ-026 SHALL keep s, cout and ovf stable while out_valid=1 and out_ready=0.
REQ-027 SHALL, with STAGES=1, register once and produce the result one cycle after acceptance.

Reset
REQ-028 SHALL, while rst=1, clear all stage valid bits immediately, making out_valid=0, in_ready=1, s=0, cout=0 and ovf=0.
REQ-029 SHALL discard in-flight operations on reset mid-operation, with no result emitted for them after rst deasserts.
REQ-030 SHALL accept input on the first rising clk edge after rst deasserts.

Configuration
REQ-031 SHALL, when macro PIPELINED_ADDER_SAT_EN is defined, saturate signed results: on ovf=1, s SHALL be 0x7F..F if the MSB of a is 0, else 0x80..0; ovf still reports the overflow and cout is unchanged.
REQ-032 SHALL, when PIPELINED_ADDER_SAT_EN is undefined, output s as the wrap-around result, with no saturation logic present.

Verification (WIDTH=8, STAGES=2)
REQ-033 SHALL cover: a=0xFF, b=0x01, cin=0, sub=0 -> 2 cycles later out_valid=1, s=0x00, cout=1, ovf=0.
REQ-034 SHALL cover: a=0x7F, b=0x01, sub=0 -> s=0x80, ovf=1, cout=0; with PIPELINED_ADDER_SAT_EN -> s=0x7F, ovf=1.
REQ-035 SHALL cover: a=0x05, b=0x07, sub=1 -> s=0xFE, cout=0, ovf=0; then a=0x80, b=0x01, sub=1 -> s=0x7F, ovf=1.
REQ-036 SHALL cover: 4 back-to-back inputs with out_ready=0 from cycle 2 -> first result held, in_ready=0; out_ready=1 -> results drained in order, one per cycle.
REQ-037 SHALL cover: rst pulsed one cycle after 2 accepted inputs -> out_valid=0 immediately and no result ever appears for those inputs.
REQ-038 SHALL cover: inputs 0x10+0x20, bubble, 0x01+0x01 -> out_valid pattern 1,0,1 with s=0x30, then 0x02.
